gyruss_filter_mixer: RTL and testbench

- Sits directly downstream of the per-channel Gyruss low-pass filter stages (bypass, light, medium, heavy).
- For each AY channel, selects one of the four filtered versions using the 2-bit filter-select value written by the sound CPU.
- Sums the selected channels in a time-multiplexed accumulator, scales and saturates the sum, then registers a 16-bit mixed sample at the filter sample rate for the final output stage.

---
 rtl/gyruss_filter_mixer_pkg.sv | 36 +++
 rtl/gyruss_filter_mixer_sat16.sv | 30 +++
 rtl/gyruss_filter_mixer.sv | 132 +++++++++++++
 tb/tb_gyruss_filter_mixer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gyruss_filter_mixer_pkg.sv
// Constants shared by the Gyruss filter mixer and its saturation stage:
// the filter-select codes, the FSM state encoding and the sample width.
package gyruss_filter_mixer_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic [1:0] FSEL_BYPASS = 2'b00;
  localparam logic [1:0] FSEL_LIGHT  = 2'b01;
  localparam logic [1:0] FSEL_MEDIUM = 2'b10;
  localparam logic [1:0] FSEL_HEAVY  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_SAT  = 2'b10
  } state_e;

  // Picks one of the four filtered versions of a channel sample.
  function automatic logic [SAMPLE_W-1:0] fsel_pick(
    input logic [1:0]          code,
    input logic [SAMPLE_W-1:0] byp,
    input logic [SAMPLE_W-1:0] lgt,
    input logic [SAMPLE_W-1:0] med,
    input logic [SAMPLE_W-1:0] hvy
  );
    logic [SAMPLE_W-1:0] s;
    case (code)
      FSEL_LIGHT:  s = lgt;
      FSEL_MEDIUM: s = med;
      FSEL_HEAVY:  s = hvy;
      default:     s = byp;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/gyruss_filter_mixer_sat16.sv
// Combinational arithmetic shift and clamp of a wide signed accumulator
// down to a 16-bit signed sample; shared by the mixing stages.
module gyruss_sat16
  import gyruss_filter_mixer_pkg::*;
#(
  parameter int ACC_W = 19,
  parameter int SHIFT = 1
) (
  input  logic signed [ACC_W-1:0]    acc_i,
  output logic signed [SAMPLE_W-1:0] sat_o
);

  localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] NEG_LIM = ACC_W'(-(2 ** (SAMPLE_W - 1)));

  logic signed [ACC_W-1:0] shifted;

  assign shifted = acc_i >>> SHIFT;

  always_comb begin
    if (shifted > POS_LIM) begin
      sat_o = POS_LIM[SAMPLE_W-1:0];
    end else if (shifted < NEG_LIM) begin
      sat_o = NEG_LIM[SAMPLE_W-1:0];
    end else begin
      sat_o = shifted[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/gyruss_filter_mixer.sv
// Per-channel filter selection and time-multiplexed mixing of the Gyruss AY
// channels into one saturated 16-bit sample per filter sample period.
module gyruss_filter_mixer
  import gyruss_filter_mixer_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int DIV   = 220,
  parameter int SHIFT = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SAMPLE_W*NCH-1:0]        ch_bypass,
  input  logic [SAMPLE_W*NCH-1:0]        ch_light,
  input  logic [SAMPLE_W*NCH-1:0]        ch_medium,
  input  logic [SAMPLE_W*NCH-1:0]        ch_heavy,
  input  logic [2*NCH-1:0]               fsel,
  input  logic                           fsel_we,
  output logic signed [SAMPLE_W-1:0]     out,
  output logic                           out_valid
);

  localparam int ACC_W = SAMPLE_W + $clog2(NCH) + 1;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = $clog2(DIV);

  if (DIV <= NCH + 2) begin : g_div_check
    $error("gyruss_filter_mixer: DIV must exceed NCH+2");
  end

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [2*NCH-1:0]            shadow_q, shadow_d;
  logic [2*NCH-1:0]            active_q, active_d;
  logic signed [SAMPLE_W-1:0]  out_q, out_d;
  logic                        valid_q, valid_d;

  logic                        tick;
  logic [SAMPLE_W-1:0]         pick;
  logic signed [ACC_W-1:0]     pick_ext;
  logic signed [SAMPLE_W-1:0]  sat_val;

  assign tick  = (cnt_q == CNT_W'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_comb begin
    int ch;
    ch   = int'(idx_q);
    pick = fsel_pick(active_q[2*ch +: 2],
                     ch_bypass[SAMPLE_W*ch +: SAMPLE_W],
                     ch_light[SAMPLE_W*ch +: SAMPLE_W],
                     ch_medium[SAMPLE_W*ch +: SAMPLE_W],
                     ch_heavy[SAMPLE_W*ch +: SAMPLE_W]);
  end

  assign pick_ext = {{(ACC_W - SAMPLE_W){pick[SAMPLE_W-1]}}, pick};

  gyruss_sat16 #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .acc_i (acc_q),
    .sat_o (sat_val)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    active_d = active_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    shadow_d = fsel_we ? fsel : shadow_q;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          // Copy from shadow_d so a write landing on the tick cycle takes effect.
          active_d = shadow_d;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = ST_ACC;
        end
      end
      ST_ACC: begin
        acc_d = acc_q + pick_ext;
        if (idx_q == IDX_W'(NCH - 1)) begin
          state_d = ST_SAT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_SAT: begin
        out_d   = sat_val;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      shadow_q <= {NCH{FSEL_BYPASS}};
      active_q <= {NCH{FSEL_BYPASS}};
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_gyruss_filter_mixer.sv
// Directed bench for gyruss_filter_mixer: two instances (SHIFT=1 and SHIFT=0)
// share stimulus; expected samples are hand-computed in each scenario task.
module tb_gyruss_filter_mixer;

  localparam int NCH   = 3;
  localparam int DIV   = 220;
  localparam int LIMIT = 600;

  logic               clk;
  logic               reset;
  logic [47:0]        ch_bypass, ch_light, ch_medium, ch_heavy;
  logic [5:0]         fsel;
  logic               fsel_we;
  logic signed [15:0] out1, out0;
  logic               valid1, valid0;

  int checks = 0;
  int errors = 0;

  gyruss_filter_mixer #(.NCH(NCH), .DIV(DIV), .SHIFT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_bypass (ch_bypass),
    .ch_light  (ch_light),
    .ch_medium (ch_medium),
    .ch_heavy  (ch_heavy),
    .fsel      (fsel),
    .fsel_we   (fsel_we),
    .out       (out1),
    .out_valid (valid1)
  );

  gyruss_filter_mixer #(.NCH(NCH), .DIV(DIV), .SHIFT(0)) dut_s0 (
    .clk       (clk),
    .reset     (reset),
    .ch_bypass (ch_bypass),
    .ch_light  (ch_light),
    .ch_medium (ch_medium),
    .ch_heavy  (ch_heavy),
    .fsel      (fsel),
    .fsel_we   (fsel_we),
    .out       (out0),
    .out_valid (valid0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] pack3(input logic signed [15:0] c0, c1, c2);
    return {c2, c1, c0};
  endfunction

  // Counts rising edges until out_valid is seen just after one; bounded.
  task automatic wait_valid(output int edges);
    bit ok;
    edges = 0;
    ok    = 1'b0;
    while (!ok && edges < LIMIT) begin
      @(posedge clk);
      edges++;
      #1;
      ok = valid1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_valid: got no out_valid after %0d clocks, required one", edges);
    end
  endtask

  task automatic write_fsel(input logic [5:0] code);
    @(negedge clk);
    fsel    = code;
    fsel_we = 1'b1;
    @(negedge clk);
    fsel_we = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic signed [15:0] e1, e0);
    checks++;
    if (out1 !== e1) begin
      errors++;
      $display("FAIL %s shift1: got %0d required %0d", name, out1, e1);
    end
    checks++;
    if (out0 !== e0) begin
      errors++;
      $display("FAIL %s shift0: got %0d required %0d", name, out0, e0);
    end
  endtask

  task automatic test_reset();
    int edges;
    reset = 1'b0; fsel = '0; fsel_we = 1'b0;
    ch_bypass = '0; ch_light = '0; ch_medium = '0; ch_heavy = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (valid1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b required 0", valid1);
    end
    expect_out("reset_out", 16'sd0, 16'sd0);
    // Release mid-period: that partial period is clock 1, each edge starts the next.
    @(negedge clk);
    reset = 1'b1;
    wait_valid(edges);
    checks++;
    if (edges + 1 != DIV + NCH + 2) begin
      errors++;
      $display("FAIL first_valid_latency: got %0d required %0d", edges + 1, DIV + NCH + 2);
    end
    expect_out("zero_inputs", 16'sd0, 16'sd0);
  endtask

  task automatic test_bypass_sum();
    int edges;
    ch_bypass = pack3(16'sd1000, 16'sd2000, 16'sd3000);
    wait_valid(edges);
    checks++;
    if (edges != DIV) begin
      errors++;
      $display("FAIL sample_spacing: got %0d required %0d", edges, DIV);
    end
    expect_out("bypass_sum", 16'sd3000, 16'sd6000);
    @(posedge clk);
    #1;
    checks++;
    if (valid1 !== 1'b0) begin
      errors++;
      $display("FAIL valid_width: got %b required 0", valid1);
    end
  endtask

  task automatic test_mixed_select();
    int edges;
    ch_bypass = pack3(16'sd32767, 16'sd32767, 16'sd32767);
    ch_light  = pack3(16'sd100,   16'sd32767, 16'sd32767);
    ch_medium = pack3(16'sd32767, -16'sd700,  16'sd32767);
    ch_heavy  = pack3(16'sd32767, 16'sd32767, 16'sd500);
    write_fsel(6'b11_10_01);
    wait_valid(edges);
    expect_out("mixed_select", -16'sd50, -16'sd100);
  endtask

  typedef struct {
    logic signed [15:0] c0, c1, c2, e1, e0;
  } vec_t;

  task automatic test_clamp();
    int   edges;
    vec_t v [9];
    v[0] = '{16'sd32767,  16'sd32767,  16'sd32767,  16'sd32767,  16'sd32767};
    v[1] = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768};
    v[2] = '{16'sd32767,  16'sd32767,  16'sd1,      16'sd32767,  16'sd32767};
    v[3] = '{16'sd32767,  16'sd32767,  16'sd2,      16'sd32767,  16'sd32767};
    v[4] = '{-16'sd32768, -16'sd32768, 16'sd0,      -16'sd32768, -16'sd32768};
    v[5] = '{-16'sd32768, -16'sd32768, -16'sd1,     -16'sd32768, -16'sd32768};
    v[6] = '{-16'sd1,     16'sd0,      16'sd0,      -16'sd1,     -16'sd1};
    v[7] = '{16'sd0,      16'sd0,      16'sd32767,  16'sd16383,  16'sd32767};
    v[8] = '{-16'sd300,   16'sd200,    16'sd50,     -16'sd25,    -16'sd50};
    write_fsel(6'b00_00_00);
    for (int i = 0; i < 9; i++) begin
      ch_bypass = pack3(v[i].c0, v[i].c1, v[i].c2);
      wait_valid(edges);
      expect_out($sformatf("clamp_vec%0d", i), v[i].e1, v[i].e0);
    end
  endtask

  task automatic test_select_timing();
    int edges;
    ch_bypass = pack3(16'sd1000, 16'sd2000, 16'sd3000);
    ch_light  = pack3(16'sd100, 16'sd200, 16'sd300);
    ch_medium = '0;
    ch_heavy  = pack3(-16'sd2000, -16'sd2000, -16'sd2000);
    wait_valid(edges);
    expect_out("sync_bypass", 16'sd3000, 16'sd6000);
    // The tick period begins 215 edges after the valid edge; ACC follows it.
    repeat (216) @(posedge clk);
    #1;
    fsel    = 6'b01_01_01;
    fsel_we = 1'b1;
    @(posedge clk);
    #1;
    fsel_we = 1'b0;
    wait_valid(edges);
    expect_out("write_in_acc_old", 16'sd3000, 16'sd6000);
    wait_valid(edges);
    expect_out("write_in_acc_new", 16'sd300, 16'sd600);
    repeat (215) @(posedge clk);
    #1;
    fsel    = 6'b11_11_11;
    fsel_we = 1'b1;
    @(posedge clk);
    #1;
    fsel_we = 1'b0;
    wait_valid(edges);
    expect_out("write_on_tick", -16'sd3000, -16'sd6000);
  endtask

  task automatic test_reset_mid();
    int edges;
    repeat (217) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (valid1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_valid: got %b required 0", valid1);
    end
    expect_out("mid_reset_out", 16'sd0, 16'sd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_valid(edges);
    checks++;
    if (edges + 1 != DIV + NCH + 2) begin
      errors++;
      $display("FAIL post_reset_latency: got %0d required %0d", edges + 1, DIV + NCH + 2);
    end
    // The heavy code written earlier is gone: reset selects bypass again.
    expect_out("post_reset_bypass", 16'sd3000, 16'sd6000);
  endtask

  initial begin
    test_reset();
    test_bypass_sum();
    test_mixed_select();
    test_clamp();
    test_select_timing();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
